// File: rtl/cache_refill_engine.sv
// Miss-refill engine for the set-associative instruction cache.
// Accepts one miss at a time, picks an LRU victim, issues a critical-word-first
// block request, forwards the missed word early and streams the block into the
// data array before writing the tag and age-status words.
module cache_refill_engine #(
    parameter int TAG_W    = 8,
    parameter int SET_W    = 4,
    parameter int OFF_W    = 4,
    parameter int NUM_WAYS = 4,
    parameter int AGE_W    = $clog2(NUM_WAYS),
    parameter int WORD_W   = 20
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [TAG_W-1:0]            i_req_tag,
    input  logic [SET_W-1:0]            i_req_set,
    input  logic [OFF_W-1:0]            i_req_offset,
    input  logic [NUM_WAYS*AGE_W-1:0]   i_req_status,
    output logic                        o_mem_req_valid,
    input  logic                        i_mem_req_ready,
    output logic [TAG_W+SET_W-1:0]      o_mem_req_addr,
    output logic [OFF_W-1:0]            o_mem_req_offset,
    input  logic                        i_mem_rsp_valid,
    output logic                        o_mem_rsp_ready,
    input  logic [WORD_W-1:0]           i_mem_rsp_data,
    output logic                        o_da_valid,
    input  logic                        i_da_ready,
    output logic [SET_W+OFF_W-1:0]      o_da_addr,
    output logic [WORD_W-1:0]           o_da_data,
    output logic [NUM_WAYS-1:0]         o_da_mask,
    output logic                        o_ta_valid,
    input  logic                        i_ta_ready,
    output logic [SET_W-1:0]            o_ta_addr,
    output logic [TAG_W-1:0]            o_ta_data,
    output logic [NUM_WAYS-1:0]         o_ta_mask,
    output logic                        o_sa_valid,
    input  logic                        i_sa_ready,
    output logic [SET_W-1:0]            o_sa_addr,
    output logic [NUM_WAYS*AGE_W-1:0]   o_sa_data,
    output logic                        o_word_valid,
    output logic [WORD_W-1:0]           o_word_data,
    output logic                        o_miss_state
);

    localparam int ST_W = NUM_WAYS * AGE_W;

    typedef enum logic [1:0] {IDLE, MREQ, FILL, META} state_t;

    // Lowest-index way holding the oldest age; way 0 when no way is that old.
    function automatic logic [NUM_WAYS-1:0] pick_victim(input logic [ST_W-1:0] st);
        logic [NUM_WAYS-1:0] oh;
        oh = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (st[w*AGE_W +: AGE_W] == AGE_W'(NUM_WAYS - 1))
                oh = NUM_WAYS'(1) << w;
        end
        if (oh == '0)
            oh[0] = 1'b1;
        return oh;
    endfunction

    // Victim becomes youngest; ways younger than the victim age by one.
    function automatic logic [ST_W-1:0] age_update(input logic [ST_W-1:0]     st,
                                                   input logic [NUM_WAYS-1:0] oh);
        logic [AGE_W-1:0] va;
        logic [AGE_W-1:0] a;
        logic [ST_W-1:0]  r;
        va = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (oh[w])
                va = st[w*AGE_W +: AGE_W];
        end
        r = st;
        for (int w = 0; w < NUM_WAYS; w++) begin
            a = st[w*AGE_W +: AGE_W];
            if (oh[w])
                r[w*AGE_W +: AGE_W] = '0;
            else if (a < va)
                r[w*AGE_W +: AGE_W] = a + 1'b1;
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       tag_q;
    logic [SET_W-1:0]       set_q;
    logic [OFF_W-1:0]       off_q;
    logic [NUM_WAYS-1:0]    victim_q;
    logic [ST_W-1:0]        status_q;
    logic [OFF_W:0]         beat_cnt_q;
    logic                   da_valid_q;
    logic [SET_W+OFF_W-1:0] da_addr_q;
    logic [WORD_W-1:0]      da_data_q;
    logic                   word_valid_q;
    logic [WORD_W-1:0]      word_data_q;
    logic                   ta_valid_q;
    logic                   sa_valid_q;

    logic req_fire;
    logic beat_take;
    logic da_fire;
    logic enter_meta;

    // Next-state decode and handshake-derived control strobes.
    always_comb begin
        state_d         = state_q;
        o_req_ready     = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_rsp_ready = 1'b0;
        req_fire        = 1'b0;
        beat_take       = 1'b0;
        enter_meta      = 1'b0;
        da_fire         = da_valid_q & i_da_ready;
        o_miss_state    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                req_fire    = i_req_valid;
                if (i_req_valid)
                    state_d = MREQ;
            end
            MREQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready)
                    state_d = FILL;
            end
            FILL: begin
                o_mem_rsp_ready = ~da_valid_q | i_da_ready;
                // Beats beyond the block length are never written.
                beat_take = i_mem_rsp_valid & o_mem_rsp_ready & ~beat_cnt_q[OFF_W];
                // All beats taken and the slot drains: the last word is written.
                if (da_fire && beat_cnt_q[OFF_W]) begin
                    enter_meta = 1'b1;
                    state_d    = META;
                end
            end
            META: begin
                if ((~ta_valid_q | i_ta_ready) && (~sa_valid_q | i_sa_ready))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Miss context, single DA slot, early-restart word and metadata valids.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tag_q        <= '0;
            set_q        <= '0;
            off_q        <= '0;
            victim_q     <= '0;
            status_q     <= '0;
            beat_cnt_q   <= '0;
            da_valid_q   <= 1'b0;
            da_addr_q    <= '0;
            da_data_q    <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            ta_valid_q   <= 1'b0;
            sa_valid_q   <= 1'b0;
        end else begin
            if (req_fire) begin
                tag_q      <= i_req_tag;
                set_q      <= i_req_set;
                off_q      <= i_req_offset;
                victim_q   <= pick_victim(i_req_status);
                status_q   <= age_update(i_req_status, pick_victim(i_req_status));
                beat_cnt_q <= '0;
            end
            word_valid_q <= beat_take & (beat_cnt_q == '0);
            if (beat_take) begin
                da_valid_q <= 1'b1;
                da_addr_q  <= {set_q, off_q + beat_cnt_q[OFF_W-1:0]};
                da_data_q  <= i_mem_rsp_data;
                beat_cnt_q <= beat_cnt_q + 1'b1;
                if (beat_cnt_q == '0)
                    word_data_q <= i_mem_rsp_data;
            end else if (da_fire) begin
                da_valid_q <= 1'b0;
            end
            if (enter_meta)
                ta_valid_q <= 1'b1;
            else if (i_ta_ready)
                ta_valid_q <= 1'b0;
            if (enter_meta)
                sa_valid_q <= 1'b1;
            else if (i_sa_ready)
                sa_valid_q <= 1'b0;
        end
    end

    assign o_mem_req_addr   = {tag_q, set_q};
    assign o_mem_req_offset = off_q;
    assign o_da_valid       = da_valid_q;
    assign o_da_addr        = da_addr_q;
    assign o_da_data        = da_data_q;
    assign o_da_mask        = victim_q;
    assign o_ta_valid       = ta_valid_q;
    assign o_ta_addr        = set_q;
    assign o_ta_data        = tag_q;
    assign o_ta_mask        = victim_q;
    assign o_sa_valid       = sa_valid_q;
    assign o_sa_addr        = set_q;
    assign o_sa_data        = status_q;
    assign o_word_valid     = word_valid_q;
    assign o_word_data      = word_data_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Scoreboard bench for cache_refill_engine: stimulus pushes expected writes,
// a monitor pops and compares on every DUT handshake.
module tb_cache_refill_engine;

    localparam int TAG_W    = 8;
    localparam int SET_W    = 4;
    localparam int OFF_W    = 4;
    localparam int NUM_WAYS = 4;
    localparam int AGE_W    = 2;
    localparam int WORD_W   = 20;
    localparam int WPB      = 16;
    localparam int ST_W     = NUM_WAYS * AGE_W;

    logic                   clk;
    logic                   arst_n;
    logic                   i_req_valid;
    logic                   o_req_ready;
    logic [TAG_W-1:0]       i_req_tag;
    logic [SET_W-1:0]       i_req_set;
    logic [OFF_W-1:0]       i_req_offset;
    logic [ST_W-1:0]        i_req_status;
    logic                   o_mem_req_valid;
    logic                   i_mem_req_ready;
    logic [TAG_W+SET_W-1:0] o_mem_req_addr;
    logic [OFF_W-1:0]       o_mem_req_offset;
    logic                   i_mem_rsp_valid;
    logic                   o_mem_rsp_ready;
    logic [WORD_W-1:0]      i_mem_rsp_data;
    logic                   o_da_valid;
    logic                   i_da_ready;
    logic [SET_W+OFF_W-1:0] o_da_addr;
    logic [WORD_W-1:0]      o_da_data;
    logic [NUM_WAYS-1:0]    o_da_mask;
    logic                   o_ta_valid;
    logic                   i_ta_ready;
    logic [SET_W-1:0]       o_ta_addr;
    logic [TAG_W-1:0]       o_ta_data;
    logic [NUM_WAYS-1:0]    o_ta_mask;
    logic                   o_sa_valid;
    logic                   i_sa_ready;
    logic [SET_W-1:0]       o_sa_addr;
    logic [ST_W-1:0]        o_sa_data;
    logic                   o_word_valid;
    logic [WORD_W-1:0]      o_word_data;
    logic                   o_miss_state;

    cache_refill_engine #(
        .TAG_W(TAG_W), .SET_W(SET_W), .OFF_W(OFF_W),
        .NUM_WAYS(NUM_WAYS), .AGE_W(AGE_W), .WORD_W(WORD_W)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_tag(i_req_tag), .i_req_set(i_req_set),
        .i_req_offset(i_req_offset), .i_req_status(i_req_status),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr(o_mem_req_addr), .o_mem_req_offset(o_mem_req_offset),
        .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready),
        .i_mem_rsp_data(i_mem_rsp_data),
        .o_da_valid(o_da_valid), .i_da_ready(i_da_ready), .o_da_addr(o_da_addr),
        .o_da_data(o_da_data), .o_da_mask(o_da_mask),
        .o_ta_valid(o_ta_valid), .i_ta_ready(i_ta_ready), .o_ta_addr(o_ta_addr),
        .o_ta_data(o_ta_data), .o_ta_mask(o_ta_mask),
        .o_sa_valid(o_sa_valid), .i_sa_ready(i_sa_ready), .o_sa_addr(o_sa_addr),
        .o_sa_data(o_sa_data),
        .o_word_valid(o_word_valid), .o_word_data(o_word_data),
        .o_miss_state(o_miss_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SET_W+OFF_W-1:0] addr;
        logic [WORD_W-1:0]      data;
        logic [NUM_WAYS-1:0]    mask;
    } da_t;
    typedef struct packed {
        logic [SET_W-1:0]    addr;
        logic [TAG_W-1:0]    tag;
        logic [NUM_WAYS-1:0] mask;
    } ta_t;
    typedef struct packed {
        logic [SET_W-1:0] addr;
        logic [ST_W-1:0]  st;
    } sa_t;

    da_t               exp_da_q[$];
    logic [WORD_W-1:0] exp_word_q[$];
    ta_t               exp_ta_q[$];
    sa_t               exp_sa_q[$];
    logic [WORD_W-1:0] mem_data_q[$];

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint req_cyc  = 0;
    int     rdy_mode = 0;
    bit     fast_mem = 1'b1;
    bit     lat_check = 1'b0;
    int     stall_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int age_of(input logic [ST_W-1:0] st, input int w);
        return int'((st >> (w * AGE_W)) & ST_W'(NUM_WAYS - 1));
    endfunction

    function automatic int model_victim(input logic [ST_W-1:0] st);
        for (int w = 0; w < NUM_WAYS; w++)
            if (age_of(st, w) == NUM_WAYS - 1) return w;
        return 0;
    endfunction

    function automatic logic [ST_W-1:0] model_status(input logic [ST_W-1:0] st);
        int v;
        int va;
        int na;
        logic [ST_W-1:0] r;
        v  = model_victim(st);
        va = age_of(st, v);
        r  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w == v)                 na = 0;
            else if (age_of(st, w) < va) na = age_of(st, w) + 1;
            else                        na = age_of(st, w);
            r = r | (ST_W'(na) << (w * AGE_W));
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- array ready drivers ----------------
    int sa_hold = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                i_da_ready = ($urandom_range(0, 3) != 0);
                i_ta_ready = ($urandom_range(0, 2) != 0);
                i_sa_ready = ($urandom_range(0, 2) != 0);
            end
            2: begin
                sa_hold    = o_sa_valid ? sa_hold + 1 : 0;
                i_da_ready = 1'b1;
                i_ta_ready = 1'b1;
                i_sa_ready = (sa_hold >= 3);
            end
            default: begin
                i_da_ready = 1'b1;
                i_ta_ready = 1'b1;
                i_sa_ready = 1'b1;
            end
        endcase
        if (stall_cycles > 0 && o_da_valid) begin
            i_da_ready   = 1'b0;
            stall_cycles = stall_cycles - 1;
        end
    end

    // ---------------- memory responder ----------------
    bit req_fire_s;
    bit rsp_fire_s;
    int beats_left = 0;
    always @(negedge clk) begin
        req_fire_s = o_mem_req_valid & i_mem_req_ready;
        rsp_fire_s = i_mem_rsp_valid & o_mem_rsp_ready;
    end
    always @(posedge clk) begin
        #1;
        if (!arst_n) begin
            beats_left      = 0;
            mem_data_q.delete();
            i_mem_req_ready = 1'b0;
            i_mem_rsp_valid = 1'b0;
            i_mem_rsp_data  = '0;
        end else begin
            if (req_fire_s) beats_left = WPB;
            if (rsp_fire_s && beats_left > 0 && mem_data_q.size() > 0) begin
                void'(mem_data_q.pop_front());
                beats_left = beats_left - 1;
            end
            i_mem_req_ready = o_mem_req_valid && (fast_mem || $urandom_range(0, 2) == 0);
            if (!(i_mem_rsp_valid && !rsp_fire_s))
                i_mem_rsp_valid = (beats_left > 0) && (mem_data_q.size() > 0) &&
                                  (fast_mem || $urandom_range(0, 2) != 0);
            i_mem_rsp_data = (mem_data_q.size() > 0) ? mem_data_q[0] : '0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit  da_pend, ta_low_exp, sa_low_exp, idle_exp, ta_done, sa_done;
    da_t da_prev;
    always @(negedge clk) begin
        da_t e;
        ta_t t;
        sa_t s;
        logic [WORD_W-1:0] w;
        if (!arst_n) begin
            exp_da_q.delete(); exp_word_q.delete(); exp_ta_q.delete(); exp_sa_q.delete();
            da_pend = 0; ta_low_exp = 0; sa_low_exp = 0; idle_exp = 0; ta_done = 0; sa_done = 0;
        end else begin
            if (idle_exp)   chk("idle_after_meta", o_req_ready, 1'b1);
            if (ta_low_exp) chk("ta_valid_drop", o_ta_valid, 1'b0);
            if (sa_low_exp) chk("sa_valid_drop", o_sa_valid, 1'b0);
            idle_exp = 0; ta_low_exp = 0; sa_low_exp = 0;
            if (da_pend) begin
                chk("da_hold_addr", o_da_addr, da_prev.addr);
                chk("da_hold_data", o_da_data, da_prev.data);
                chk("da_hold_valid", o_da_valid, 1'b1);
            end
            if (o_da_valid && !i_da_ready) chk("rsp_ready_stall", o_mem_rsp_ready, 1'b0);
            da_pend = o_da_valid && !i_da_ready;
            da_prev.addr = o_da_addr; da_prev.data = o_da_data; da_prev.mask = o_da_mask;
            if (o_da_valid && i_da_ready) begin
                if (exp_da_q.size() == 0) chk("da_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_da_q.pop_front();
                    chk("da_addr", o_da_addr, e.addr);
                    chk("da_data", o_da_data, e.data);
                    chk("da_mask", o_da_mask, e.mask);
                end
            end
            if (o_word_valid) begin
                if (exp_word_q.size() == 0) chk("word_unexpected", 1'b1, 1'b0);
                else begin
                    w = exp_word_q.pop_front();
                    chk("word_data", o_word_data, w);
                    if (lat_check) chk("word_latency", 64'(cyc - req_cyc), 64'd3);
                end
            end
            if (o_ta_valid && i_ta_ready) begin
                if (exp_ta_q.size() == 0) chk("ta_unexpected", 1'b1, 1'b0);
                else begin
                    t = exp_ta_q.pop_front();
                    chk("ta_addr", o_ta_addr, t.addr);
                    chk("ta_data", o_ta_data, t.tag);
                    chk("ta_mask", o_ta_mask, t.mask);
                end
                ta_low_exp = 1; ta_done = 1;
            end
            if (o_sa_valid && i_sa_ready) begin
                if (exp_sa_q.size() == 0) chk("sa_unexpected", 1'b1, 1'b0);
                else begin
                    s = exp_sa_q.pop_front();
                    chk("sa_addr", o_sa_addr, s.addr);
                    chk("sa_data", o_sa_data, s.st);
                end
                sa_low_exp = 1; sa_done = 1;
            end
            if (ta_done && sa_done) begin
                idle_exp = 1; ta_done = 0; sa_done = 0;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic issue(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                         input logic [OFF_W-1:0] off, input logic [ST_W-1:0] st,
                         input logic [NUM_WAYS-1:0] mask_e, input logic [ST_W-1:0] st_e);
        da_t e;
        ta_t t;
        sa_t s;
        logic [WORD_W-1:0] d;
        int n;
        for (int k = 0; k < WPB; k++) begin
            d = WORD_W'($urandom);
            mem_data_q.push_back(d);
            e.addr = {set, OFF_W'((int'(off) + k) % WPB)};
            e.data = d;
            e.mask = mask_e;
            exp_da_q.push_back(e);
            if (k == 0) exp_word_q.push_back(d);
        end
        t.addr = set; t.tag = tag; t.mask = mask_e;
        exp_ta_q.push_back(t);
        s.addr = set; s.st = st_e;
        exp_sa_q.push_back(s);
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_req_tag = tag; i_req_set = set;
        i_req_offset = off; i_req_status = st;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_req_ready) begin req_cyc = cyc; break; end
            n++;
            if (n > 3000) begin chk("req_accept_timeout", 1'b0, 1'b1); break; end
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_tag = TAG_W'($urandom); i_req_set = SET_W'($urandom);
        i_req_offset = OFF_W'($urandom); i_req_status = ST_W'($urandom);
    endtask

    task automatic issue_rand();
        logic [ST_W-1:0] st;
        st = ST_W'($urandom);
        issue(TAG_W'($urandom), SET_W'($urandom), OFF_W'($urandom), st,
              NUM_WAYS'(1) << model_victim(st), model_status(st));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 3000 && !(exp_da_q.size() == 0 && exp_word_q.size() == 0 &&
                             exp_ta_q.size() == 0 && exp_sa_q.size() == 0 && o_req_ready)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (n < 3000), 1'b1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        arst_n = 1'b0;
        i_req_valid = 1'b0;
        stall_cycles = 0;
        #1;
        chk("rst_req_ready", o_req_ready, 1'b1);
        chk("rst_miss_state", o_miss_state, 1'b0);
        chk("rst_mem_req_valid", o_mem_req_valid, 1'b0);
        chk("rst_mem_req_addr", o_mem_req_addr, '0);
        chk("rst_mem_req_offset", o_mem_req_offset, '0);
        chk("rst_mem_rsp_ready", o_mem_rsp_ready, 1'b0);
        chk("rst_da_valid", o_da_valid, 1'b0);
        chk("rst_da_addr", o_da_addr, '0);
        chk("rst_da_data", o_da_data, '0);
        chk("rst_da_mask", o_da_mask, '0);
        chk("rst_ta_valid", o_ta_valid, 1'b0);
        chk("rst_ta_addr", o_ta_addr, '0);
        chk("rst_ta_data", o_ta_data, '0);
        chk("rst_ta_mask", o_ta_mask, '0);
        chk("rst_sa_valid", o_sa_valid, 1'b0);
        chk("rst_sa_addr", o_sa_addr, '0);
        chk("rst_sa_data", o_sa_data, '0);
        chk("rst_word_valid", o_word_valid, 1'b0);
        chk("rst_word_data", o_word_data, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        arst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        arst_n = 1'b0;
        i_req_valid = 1'b0; i_req_tag = '0; i_req_set = '0; i_req_offset = '0; i_req_status = '0;
        i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
        i_da_ready = 1'b1; i_ta_ready = 1'b1; i_sa_ready = 1'b1;
        do_reset();

        // Wrap-around burst, oldest-way victim, minimum word latency.
        rdy_mode = 0; fast_mem = 1; lat_check = 1;
        issue(8'hA5, 4'h5, 4'd13, 8'h72, 4'b0100, 8'h87);
        drain();
        lat_check = 0;

        // No way at max age: victim way 0; DA backpressure mid-burst.
        issue(8'h3C, 4'h9, 4'd2, 8'h00, 4'b0001, 8'h00);
        n = 0;
        while (exp_da_q.size() > 8 && n < 500) begin @(negedge clk); n++; end
        stall_cycles = 3;
        drain();

        // Tag write completes well ahead of the status write.
        rdy_mode = 2;
        issue(8'h11, 4'hC, 4'd0, 8'h1B, 4'b0001, 8'h6C);
        drain();

        // Reset mid-fill, then a clean refill.
        rdy_mode = 0; fast_mem = 1;
        issue_rand();
        n = 0;
        while (exp_da_q.size() > WPB - 7 && n < 500) begin @(negedge clk); n++; end
        chk("reached_beat7", (n < 500), 1'b1);
        do_reset();
        issue_rand();
        drain();

        // Randomized traffic, requests often presented while busy.
        rdy_mode = 1; fast_mem = 0;
        for (int i = 0; i < 24; i++) begin
            issue_rand();
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_refill_engine.md
# cache_refill_engine

Parametrised miss-refill engine for the set-associative instruction cache, sitting between the hit/miss lookup stage and the external memory interface. On an accepted miss it selects a victim way from the per-set age (LRU) status, issues one critical-word-first block request to memory, and forwards the missed word as soon as it arrives (early restart). It streams each returned word into the data array with backpressure, then writes the tag array and the updated status word. Relative to the fixed 4-way/16-word miss handler, this block adds generic ways, depth and width, full valid/ready handshakes on every array port, and wrap-around burst ordering.

## Interface
Parameters:
- TAG_W, 8, tag bits per address
- SET_W, 4, set-index bits
- OFF_W, 4, word-offset bits; block holds WPB = 2**OFF_W words
- NUM_WAYS, 4, associativity; power of two, ≥2
- AGE_W, $clog2(NUM_WAYS), age bits per way in the status word
- WORD_W, 20, instruction word width

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  miss request valid
- o_req_ready  out  1  engine idle, can accept a request
- i_req_tag / i_req_set / i_req_offset  in  TAG_W / SET_W / OFF_W  missed address fields
- i_req_status  in  NUM_WAYS*AGE_W  status word for the set; way w at bits [w*AGE_W +: AGE_W]
- o_mem_req_valid  out  1  block request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  TAG_W+SET_W  {tag,set}
- o_mem_req_offset  out  OFF_W  first word to return
- i_mem_rsp_valid / o_mem_rsp_ready  in/out  1  response beat handshake
- i_mem_rsp_data  in  WORD_W  response beat
- o_da_valid / i_da_ready  out/in  1  data-array write handshake
- o_da_addr  out  SET_W+OFF_W  {set,word index}
- o_da_data  out  WORD_W;  o_da_mask  out  NUM_WAYS  one-hot victim
- o_ta_valid / i_ta_ready  out/in  1;  o_ta_addr  out  SET_W;  o_ta_data  out  TAG_W;  o_ta_mask  out  NUM_WAYS
- o_sa_valid / i_sa_ready  out/in  1;  o_sa_addr  out  SET_W;  o_sa_data  out  NUM_WAYS*AGE_W
- o_word_valid  out  1  one-cycle pulse, missed word
- o_word_data  out  WORD_W
- o_miss_state  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, MREQ, FILL, META.
  - IDLE→MREQ on i_req_valid&o_req_ready. Latch tag, set, offset, victim, and new status.
  - MREQ→FILL on i_mem_req_ready.
  - FILL→META when the DA write of beat WPB-1 handshakes.
  - META→IDLE once both TA and SA writes have handshaked, in either order or in the same cycle.
- o_req_ready = (state==IDLE). A request presented outside IDLE is ignored and must be held by the sender.
- Victim selection: the lowest-index way with age == NUM_WAYS-1. If no way has that age, the victim is way 0.
- Status update: the victim's age becomes 0. Every way with age < the victim's old age increments by 1. All other ways are unchanged.
- Beat k (0..WPB-1) is word (offset+k) mod WPB, with natural OFF_W wrap.
  - Beat counter is OFF_W+1 bits wide.
  - o_da_addr = {set, offset+k}.
- o_mem_rsp_ready = (state==FILL) & (~o_da_valid | i_da_ready). There is one registered DA slot and no other buffer.
- Beat 0 drives o_word_valid for one cycle, with o_word_data = that beat. There is no backpressure on this output.
- o_ta_data = latched tag. o_ta_mask = o_da_mask = victim one-hot. o_sa_data = updated status word.
- Each *_valid, once raised, holds its data stable until its ready is high.
- Response beats while not in FILL are not accepted, since rsp_ready is low.

## Timing
- Reset: state IDLE. All outputs and registers are 0, except o_req_ready=1.
- Request handshake at edge T: o_miss_state=1 and o_mem_req_valid=1 from T+1.
- Beat accepted at edge E: o_da_valid=1 from E+1. For beat 0, o_word_valid=1 during E+1 only.
- Minimum miss-to-word latency is 3 cycles: request at edge 0, mem ready in cycle 1, beat in cycle 2, word in cycle 3.
- With all readies high, beats stream one per cycle.
- Last DA handshake at edge L: o_ta_valid=o_sa_valid=1 from L+1.
- Final metadata handshake at edge M: IDLE and o_req_ready=1 from M+1. Back-to-back misses are therefore separated by one idle cycle.
- arst_n asserted mid-operation: immediate return to reset values. No partial writes are completed.

## Test plan
- NUM_WAYS=4, status 0x72 (w0=2, w1=0, w2=3, w3=1) → o_da_mask=o_ta_mask=4'b0100, o_sa_data=0x87.
- offset=13, set=5, 16 beats D0..D15 → DA addrs 0x5D,0x5E,0x5F,0x50..0x5C with data D0..D15. o_word_data=D0 in the cycle after the first beat.
- i_da_ready low for 3 cycles mid-burst → o_mem_rsp_ready low, o_da_addr/data held. No beat lost or duplicated; the total is 16 DA writes.
- Status with no age==3 (0x00) → victim way 0 (mask 4'b0001). New status: way0=0, others unchanged, giving 0x00.
- i_ta_ready high 2 cycles before i_sa_ready → IDLE one edge after the SA handshake. o_ta_valid low after its own handshake.
- arst_n pulsed during FILL at beat 7 → all outputs 0, o_req_ready=1. A new request then runs a clean full refill.
